// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Purpose: Shared types and constants for the load/store memory master:
//          access size encoding, FSM state encoding, and the alignment rule.
// Rev    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    BYTE    = 2'd0,
    HALF    = 2'd1,
    WORD    = 2'd2,
    ILLEGAL = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  // A request is rejected when its size is illegal or it is not naturally
  // aligned to its own size.
  function automatic logic is_bad_req(input logic [1:0] sz, input logic [1:0] off);
    return (sz == ILLEGAL) ||
           ((sz == HALF) && off[0]) ||
           ((sz == WORD) && (off != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_lane_align
// Purpose: Purely combinational little-endian lane steering.
//          Load path : memory word + offset/size/unsigned -> extended data.
//          Store path: old word + new data + offset/size  -> merged word.
// Ports  : i_word      memory read word
//          i_offset    byte offset within the word
//          i_size      access size (BYTE/HALF/WORD)
//          i_unsigned  zero-extend loads when 1
//          i_wdata     right-aligned store data
//          o_load_data extended load result
//          o_store_word word with the addressed lane replaced
// Rev    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [31:0] w_shifted;

  // Bring the addressed lane down to bit 0 before extension.
  assign w_shifted = i_word >> {i_offset, 3'b000};

  always_comb begin
    o_load_data = w_shifted;
    unique case (i_size)
      BYTE:    o_load_data = i_unsigned ? {24'd0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
      HALF:    o_load_data = i_unsigned ? {16'd0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: o_load_data = w_shifted;
    endcase
  end

  always_comb begin
    o_store_word = i_word;
    unique case (i_size)
      BYTE:    o_store_word[{i_offset, 3'b000} +: 8]     = i_wdata[7:0];
      HALF:    o_store_word[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_store_word = i_wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module : lsu_mem_master
// Purpose: Load/store initiator for a single-port, word-wide data memory with
//          a one-cycle registered read. Sub-word stores are done as
//          read-modify-write; loads are sign/zero extended.
// Ports  : clk, reset_n             clock, async active-low reset
//          req_valid/req_ready      request handshake (ready only in IDLE)
//          req_we/size/unsigned/addr/wdata  request fields
//          rsp_valid/rsp_ready      response handshake
//          rsp_rdata/rsp_err        response payload
//          mem_addr/mem_wdata/mem_rw  memory command (word index, data, write)
//          mem_rdata                registered memory read data
// Rev    : 1.0 - initial release
// ============================================================================
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rw,
  input  logic [31:0]       mem_rdata
);

  state_e      r_state;
  state_e      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;

  logic        w_bad;
  logic [31:0] w_word_idx;
  logic [31:0] w_load_data;
  logic [31:0] w_store_word;

  assign w_bad      = is_bad_req(req_size, req_addr[1:0]);
  assign w_word_idx = 32'(req_addr >> 2);
  assign req_ready  = (r_state == IDLE);
  assign rsp_valid  = (r_state == RESP);

  lsu_lane_align u_align (
    .i_word       (mem_rdata),
    .i_offset     (r_off),
    .i_size       (r_size),
    .i_unsigned   (r_uns),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (req_valid) begin
        if (w_bad)                               w_next = RESP;
        else if (req_we && (req_size == WORD))   w_next = WR;
        else                                     w_next = RD;
      end
      RD:   w_next = MRG;
      MRG:  w_next = r_we ? WR : RESP;
      WR:   w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we      <= 1'b0;
      r_size    <= 2'd0;
      r_uns     <= 1'b0;
      r_off     <= 2'd0;
      r_wdata   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_rw    <= 1'b0;
    end else begin
      // Write strobe is high exactly while the FSM sits in WR.
      mem_rw <= (w_next == WR);
      unique case (r_state)
        IDLE: if (req_valid) begin
          r_we      <= req_we;
          r_size    <= req_size;
          r_uns     <= req_unsigned;
          r_off     <= req_addr[1:0];
          r_wdata   <= req_wdata;
          rsp_rdata <= 32'd0;
          rsp_err   <= w_bad;
          // Rejected requests leave the memory port untouched.
          if (!w_bad) begin
            mem_addr <= w_word_idx;
            if (req_we && (req_size == WORD)) mem_wdata <= req_wdata;
          end
        end
        MRG: begin
          if (r_we) mem_wdata <= w_store_word;
          else      rsp_rdata <= w_load_data;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module : tb_lsu_mem_master
// Purpose: Scoreboard bench for lsu_mem_master. A byte-array reference memory
//          predicts every response and every memory write; a monitor pops the
//          expectations as the DUT presents responses and write strobes.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_rw;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_rdata(mem_rdata)
  );

  // Environment memory: 16 words, registered read, write on mem_rw.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (mem_rw) mem[mem_addr[3:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[3:0]];
  end

  // Reference memory as plain bytes.
  logic [7:0] rb [64];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wq[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int last_hs_cyc = -1;
  int hold = 0;
  bit rnd_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Response consumer: changes away from both edges.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hold > 0) begin rsp_ready = 1'b0; hold--; end
      else rsp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard checker.
  bit          seen = 0, hold_prev = 0;
  int          first_cyc = 0;
  logic [31:0] p_rdata;
  logic        p_err;
  exp_t        m_e;
  wr_t         m_w;
  int          m_d;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      wq.delete();
      seen = 0;
      hold_prev = 0;
    end else begin
      if (rsp_valid) chk(!req_ready, "req_ready_low_in_resp", 32'(req_ready), 32'd0);
      if (hold_prev) begin
        chk(rsp_valid, "rsp_valid_held", 32'(rsp_valid), 32'd1);
        chk(rsp_rdata == p_rdata && rsp_err == p_err, "rsp_payload_stable", rsp_rdata, p_rdata);
      end
      if (rsp_valid && !seen) begin seen = 1; first_cyc = cyc; end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk(0, "unexpected_rsp", rsp_rdata, 32'd0);
        else begin
          m_e = exp_q.pop_front();
          chk(rsp_rdata == m_e.rdata, "rsp_rdata", rsp_rdata, m_e.rdata);
          chk(rsp_err == m_e.err, "rsp_err", 32'(rsp_err), 32'(m_e.err));
          m_d = first_cyc - m_e.acc;
          // Rejections must respond no later than the edge after acceptance.
          if (m_e.err) chk(m_d <= 1, "err_latency", 32'(m_d), 32'd1);
          else         chk(m_d == m_e.lat, "latency", 32'(m_d), 32'(m_e.lat));
        end
        last_hs_cyc = cyc + 1;
        seen = 0;
      end
      hold_prev = rsp_valid && !rsp_ready;
      p_rdata = rsp_rdata;
      p_err = rsp_err;
      if (mem_rw) begin
        if (wq.size() == 0) chk(0, "unexpected_write", mem_addr, 32'd0);
        else begin
          m_w = wq.pop_front();
          chk(mem_addr == m_w.addr, "write_addr", mem_addr, m_w.addr);
          chk(mem_wdata == m_w.data, "write_data", mem_wdata, m_w.data);
        end
      end
    end
  end

  // Issue one request; expected results come from the byte reference.
  task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd, input bit commit);
    exp_t e;
    wr_t  w;
    int   n, nb, base;
    logic [31:0] v;
    logic [7:0]  tmp [4];
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) begin
      chk(0, "accept_timeout", 32'(n), 32'd60);
      req_valid = 0;
      return;
    end
    @(posedge clk); #1;
    e.acc = cyc;
    chk(e.acc > last_hs_cyc, "accept_after_handshake", 32'(e.acc), 32'(last_hs_cyc + 1));
    e.err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
    nb = 1 << sz;
    base = int'(addr) & ~3;
    e.rdata = 32'd0;
    e.lat = 0;
    if (!e.err && !we) begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v |= 32'(rb[int'(addr) + i]) << (8 * i);
      if (!uns && nb < 4 && v[8 * nb - 1]) v |= 32'hFFFF_FFFF << (8 * nb);
      e.rdata = v;
      e.lat = 2;
    end else if (!e.err) begin
      for (int i = 0; i < 4; i++) tmp[i] = rb[base + i];
      for (int i = 0; i < nb; i++) tmp[(int'(addr) - base) + i] = wd[8 * i +: 8];
      if (commit) for (int i = 0; i < 4; i++) rb[base + i] = tmp[i];
      w.addr = addr >> 2;
      w.data = {tmp[3], tmp[2], tmp[1], tmp[0]};
      wq.push_back(w);
      e.lat = (sz == 2'd2) ? 1 : 3;
    end
    if (commit) exp_q.push_back(e);
    req_valid = 0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin @(negedge clk); n++; end
    chk(n < 200, "drain_timeout", 32'(n), 32'd200);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    for (int i = 0; i < 64; i++) rb[i] = 8'd0;
    reset_n = 0; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    chk(req_ready == 1'b1, "reset_req_ready", 32'(req_ready), 32'd1);
    chk(rsp_valid == 1'b0, "reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk(rsp_err == 1'b0, "reset_rsp_err", 32'(rsp_err), 32'd0);
    chk(mem_rw == 1'b0, "reset_mem_rw", 32'(mem_rw), 32'd0);
    chk(rsp_rdata == 32'd0, "reset_rsp_rdata", rsp_rdata, 32'd0);
    chk(mem_addr == 32'd0, "reset_mem_addr", mem_addr, 32'd0);
    chk(mem_wdata == 32'd0, "reset_mem_wdata", mem_wdata, 32'd0);
    reset_n = 1;

    // Word store / load round trip.
    issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1);
    issue(0, 2'd2, 0, 32'h10, 32'h0, 1);
    // Read-modify-write byte store.
    issue(1, 2'd2, 0, 32'h10, 32'h11223344, 1);
    issue(1, 2'd0, 0, 32'h11, 32'h555555AA, 1);
    issue(0, 2'd2, 0, 32'h10, 32'h0, 1);
    // Extension cases on 0x80FF7F01.
    issue(1, 2'd2, 0, 32'h20, 32'h80FF7F01, 1);
    issue(0, 2'd0, 0, 32'h22, 32'h0, 1);
    issue(0, 2'd0, 1, 32'h22, 32'h0, 1);
    issue(0, 2'd1, 0, 32'h22, 32'h0, 1);
    issue(0, 2'd0, 0, 32'h20, 32'h0, 1);
    issue(0, 2'd1, 1, 32'h20, 32'h0, 1);
    issue(1, 2'd1, 0, 32'h26, 32'hFFFF8001, 1);
    // Rejected requests.
    issue(0, 2'd1, 0, 32'h21, 32'h0, 1);
    issue(1, 2'd2, 0, 32'h22, 32'hCAFEF00D, 1);
    issue(1, 2'd3, 0, 32'h20, 32'h12345678, 1);
    issue(0, 2'd3, 1, 32'h24, 32'h0, 1);

    // Backpressure with a request waiting behind the response.
    drain();
    hold = 8;
    issue(0, 2'd2, 0, 32'h20, 32'h0, 1);
    issue(0, 2'd0, 1, 32'h23, 32'h0, 1);

    // Randomized traffic with random consumer stalls.
    rnd_ready = 1;
    for (int k = 0; k < 150; k++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 63)), $urandom, 1);
    end
    drain();

    // Reset during the write cycle of a sub-word store.
    rnd_ready = 0;
    issue(1, 2'd0, 0, 32'h11, 32'h000000EE, 0);
    n = 0;
    while (!mem_rw && n < 10) begin @(negedge clk); n++; end
    chk(mem_rw == 1'b1, "reach_wr", 32'(mem_rw), 32'd1);
    #2 reset_n = 0;
    #1;
    chk(mem_rw == 1'b0, "async_reset_mem_rw", 32'(mem_rw), 32'd0);
    chk(req_ready == 1'b1, "async_reset_idle", 32'(req_ready), 32'd1);
    chk(rsp_valid == 1'b0, "async_reset_no_rsp", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk(rsp_valid == 1'b0, "no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    end
    issue(0, 2'd2, 0, 32'h10, 32'h0, 1);
    drain();
    chk(wq.size() == 0, "pending_writes", 32'(wq.size()), 32'd0);

    // Memory image must equal the reference byte memory.
    @(negedge clk);
    for (int i = 0; i < 16; i++)
      chk(mem[i] == {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]}, "mem_image",
          mem[i], {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
